// File: rtl/nms_window_if.sv
// Streaming bundle for the NMS stage: three aligned magnitude rows plus angle in,
// suppressed magnitude with valid/frame_done out.
interface nms_window_if #(
  parameter int MAG_W = 20
);
  logic             in_valid;
  logic [MAG_W-1:0] row1;
  logic [MAG_W-1:0] row2;
  logic [MAG_W-1:0] row3;
  logic [1:0]       ang;
  logic [MAG_W-1:0] out_mag;
  logic             out_valid;
  logic             frame_done;

  modport master (
    output in_valid, row1, row2, row3, ang,
    input  out_mag, out_valid, frame_done
  );

  modport slave (
    input  in_valid, row1, row2, row3, ang,
    output out_mag, out_valid, frame_done
  );
endinterface

// File: rtl/nms_window.sv
// Canny non-maximum suppression over a 3x3 window, two-stage pipeline with border masking.
// Optional magnitude floor enabled by defining NMS_THRESH_EN (uses LOW_TH).
module nms_window #(
  parameter int               WIDTH  = 320,
  parameter int               HEIGHT = 240,
  parameter int               MAG_W  = 20,
  parameter logic [MAG_W-1:0] LOW_TH = MAG_W'(64)
) (
  input logic         clk,
  input logic         rst,
  nms_window_if.slave bus
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  // w_q[r][c]: r=0 top row, c=0 newest column
  logic [2:0][2:0][MAG_W-1:0] w_q;
  logic [1:0]       ang_new_q, ang_ctr_q;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             border_q, border_d;
  logic             last_q, last_d;
  logic             v1_q;
  logic [MAG_W-1:0] out_mag_q, out_mag_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [MAG_W-1:0] ctr, nb_a, nb_b;
  logic             keep;

  // Border flag is derived from the incoming position; the centre is one column behind,
  // so incoming col 0 means centre col WIDTH-1 and incoming col 1 means centre col 0.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end else begin
      col_d = col_q + CW'(1);
    end
    border_d = (col_q == '0) || (col_q == CW'(1)) || (row_q == '0) || (row_q == ROW_LAST);
    last_d   = (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= '0;
      ang_new_q <= '0;
      ang_ctr_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      border_q  <= 1'b0;
      last_q    <= 1'b0;
      v1_q      <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        w_q[0]    <= {w_q[0][1], w_q[0][0], bus.row1};
        w_q[1]    <= {w_q[1][1], w_q[1][0], bus.row2};
        w_q[2]    <= {w_q[2][1], w_q[2][0], bus.row3};
        ang_new_q <= bus.ang;
        ang_ctr_q <= ang_new_q;
        col_q     <= col_d;
        row_q     <= row_d;
        border_q  <= border_d;
        last_q    <= last_d;
      end
    end
  end

  always_comb begin
    ctr  = w_q[1][1];
    nb_a = w_q[1][0];
    nb_b = w_q[1][2];
    case (ang_ctr_q)
      2'd1: begin nb_a = w_q[0][0]; nb_b = w_q[2][2]; end
      2'd2: begin nb_a = w_q[0][1]; nb_b = w_q[2][1]; end
      2'd3: begin nb_a = w_q[0][2]; nb_b = w_q[2][0]; end
      default: begin nb_a = w_q[1][0]; nb_b = w_q[1][2]; end
    endcase
    keep = (ctr >= nb_a) && (ctr >= nb_b) && !border_q;
`ifdef NMS_THRESH_EN
    keep = keep && (ctr >= LOW_TH);
`else
`endif
    out_mag_d    = out_mag_q;
    if (v1_q) begin
      out_mag_d = keep ? ctr : '0;
    end
    out_valid_d  = v1_q;
    frame_done_d = v1_q && last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_mag_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_mag_q    <= out_mag_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_mag    = out_mag_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/nms_window.md
# nms_window

Non-maximum-suppression stage of the Canny pipeline, directly downstream of the 3-row magnitude/angle line buffer. It consumes three vertically aligned 20-bit gradient-magnitude streams plus the 2-bit quantised gradient angle and builds a 3x3 window. For each centre pixel it keeps the magnitude only if it is a local maximum along the gradient direction, and zeroes it otherwise. Frame borders are forced to zero, and the result feeds the hysteresis/threshold stage.

## Interface
- `WIDTH`, 320: pixels per line.
- `HEIGHT`, 240: lines per frame.
- `MAG_W`, 20: magnitude width.
- `LOW_TH`, 20'd64: suppression floor, used only with `NMS_THRESH_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: row1/row2/row3/ang carry one new column this cycle. Upstream `ld` is delayed one cycle to match the registered line-buffer outputs.
- `row1` in MAG_W: top row (oldest line).
- `row2` in MAG_W: middle row.
- `row3` in MAG_W: bottom row (newest line).
- `ang` in 2: angle of the row2 sample. 0 = 0°, 1 = 45°, 2 = 90°, 3 = 135°.
- `out_mag` out MAG_W: suppressed magnitude.
- `out_valid` out 1: one-cycle pulse per accepted input.
- `frame_done` out 1: pulse coincident with the last output of a frame.

## Operation
- Window: 3 rows x 3 columns of MAG_W registers, w[r][c], where r = 0 top..2 bottom and c = 0 newest..2 oldest.
  - On in_valid, each row shifts c0→c1→c2 and loads row1/row2/row3 into c0.
  - ang is delayed one accepted sample so that it aligns with centre w[1][1].
- Counters: `col` 0..WIDTH-1 and `row` 0..HEIGHT-1 give the position of the incoming sample in the middle-row stream.
  - They advance on in_valid only.
  - col wraps to 0 and increments row; row wraps after HEIGHT-1.
  - The centre position is (row, col-1), or (row-1, WIDTH-1) when col==0.
- Neighbour pair chosen by the delayed angle:
  - 0: w[1][0], w[1][2].
  - 1: w[0][0], w[2][2] (top-right, bottom-left).
  - 2: w[0][1], w[2][1].
  - 3: w[0][2], w[2][0].
- Keep rule: centre ≥ both neighbours (unsigned compare, ties kept). Otherwise the output is 0.
- Border rule: output is 0 if the centre column is 0 or WIDTH-1, or the centre row is 0 or HEIGHT-1.
- The first output after reset or a frame wrap is 0; it is a dummy with no valid centre.
- Each accepted sample produces exactly one output. The output stream lags the pixel stream by one pixel, and the final pixel of a frame is never emitted; it is a border pixel.
- `frame_done` pulses with the output produced by the sample at (HEIGHT-1, WIDTH-1).

## Timing
- Stage 1: window, delayed angle, counters and stage-1 valid flag register on in_valid.
- Stage 2: compare, border mask and output register.
- Latency: in_valid in cycle t gives out_valid/out_mag in cycle t+2.
- in_valid may be held high continuously or gapped arbitrarily.
  - During gaps the window and counters hold.
  - out_valid is low.
  - out_mag holds its last value.
- Reset (asynchronous, any cycle, including mid-frame):
  - out_mag=0, out_valid=0, frame_done=0.
  - Window, delayed angle, col and row all 0.
  - The first sample after release is treated as (0,0).
- in_valid is ignored while rst is high.

## Configuration
- `NMS_THRESH_EN` defined: a kept centre with magnitude < LOW_TH is output as 0. The comparator is added in stage 2, and latency is unchanged.
- Not defined: no floor; the kept centre magnitude passes unmodified, and LOW_TH is unused.

## Test plan
- Reset then idle -> out_mag=0, out_valid=0, frame_done=0 indefinitely.
- All-zero frame, WIDTH=8, HEIGHT=4, in_valid continuous -> 32 out_valid pulses, every out_mag=0, frame_done only on the 32nd pulse, each pulse 2 cycles after its sample.
- Interior centre=100, ang=0, left=90, right=100 -> 100 (tie kept). Same with right=101 -> 0.
- Centre=500 at (2,3) for each ang 0..3, with one in-direction neighbour=501 and all off-direction neighbours=900 -> 0. With the in-direction neighbours both 499 -> 500.
- Centre=1000 at column 0 or row HEIGHT-1 with all neighbours 0 -> 0 (border).
- Assert rst mid-row with in_valid gapped 1-on/2-off -> outputs clear immediately. The next sample is treated as (0,0), and the stall gaps never generate out_valid.
- `NMS_THRESH_EN`, LOW_TH=64: kept centre 63 -> 0, kept centre 64 -> 64.
